// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART shift-register blocks.
//   uart_tx_state_e : unloader state encoding. SEND_CR and SEND_LF exist in
//                     every build but are only reached when the CR/LF
//                     terminator is compiled in.
//   ASCII_CR/LF     : line terminator characters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        SEND_CR = 3'd2,
        SEND_LF = 3'd3,
        FINISH  = 3'd4
    } uart_tx_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_sr_output.sv
// uart_sr_output
// Parallel-to-serial character unloader for the UART transmitter. A load
// strobe captures a packed block of CHARACTER_COUNT characters. The block
// then sends them one per valid/ready transfer, starting at the highest slot
// and ending at slot 0, so a block packed by the receive side is echoed back
// in arrival order.
//
// Optional build macro: UART_SR_OUTPUT_CRLF_EN appends 0x0D, 0x0A after
// slot 0. Each terminator is zero-extended to DATA_WIDTH.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   ena      : global enable; all state holds while low
//   load     : capture sr_data and start a block (ignored while busy)
//   sr_data  : packed block, slot i = [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   tx_data  : character offered to the transmitter
//   tx_valid : tx_data is valid
//   tx_ready : transmitter accepts tx_data this cycle
//   busy     : block in progress
//   done     : one-cycle pulse after the final character is accepted
module uart_sr_output
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned CHARACTER_COUNT = 10
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ena,
    input  logic                                  load,
    input  logic [DATA_WIDTH*CHARACTER_COUNT-1:0] sr_data,
    output logic [DATA_WIDTH-1:0]                 tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy,
    output logic                                  done
);

    localparam int unsigned BLOCK_W   = DATA_WIDTH * CHARACTER_COUNT;
    localparam int unsigned IDX_W_RAW = $clog2(CHARACTER_COUNT + 2);
    localparam int unsigned IDX_W     = (IDX_W_RAW < 1) ? 1 : IDX_W_RAW;
    localparam int unsigned TOP_SLOT  = CHARACTER_COUNT - 1;

    uart_tx_state_e        state;
    logic [BLOCK_W-1:0]    buffer;
    logic [IDX_W-1:0]      index;
    logic [DATA_WIDTH-1:0] next_slot_c;
    logic                  xfer_c;

    // A tx_ready seen while disabled is not a transfer.
    assign xfer_c = tx_valid && tx_ready && ena;

    // Character in the slot below the current index; loaded after a transfer.
    always_comb begin
        next_slot_c = '0;
        for (int i = 0; i < int'(CHARACTER_COUNT); i++) begin
            if (IDX_W'(i) == (index - IDX_W'(1))) begin
                next_slot_c = buffer[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State machine with registered outputs; nothing moves while ena is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            buffer   <= '0;
            index    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        buffer   <= sr_data;
                        index    <= IDX_W'(TOP_SLOT);
                        tx_data  <= sr_data[TOP_SLOT*DATA_WIDTH +: DATA_WIDTH];
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end

                SEND: begin
                    if (xfer_c) begin
                        if (index != '0) begin
                            index   <= index - IDX_W'(1);
                            tx_data <= next_slot_c;
                        end else begin
`ifdef UART_SR_OUTPUT_CRLF_EN
                            tx_data <= DATA_WIDTH'(ASCII_CR);
                            state   <= SEND_CR;
`else
                            tx_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= FINISH;
`endif
                        end
                    end
                end

`ifdef UART_SR_OUTPUT_CRLF_EN
                SEND_CR: begin
                    if (xfer_c) begin
                        tx_data <= DATA_WIDTH'(ASCII_LF);
                        state   <= SEND_LF;
                    end
                end

                SEND_LF: begin
                    if (xfer_c) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end
                end
`endif

                FINISH: begin
                    // load is dropped here too; the block is still busy.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sr_output.sv
// tb_uart_sr_output
// Directed bench for uart_sr_output with DATA_WIDTH=8, CHARACTER_COUNT=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours UART_SR_OUTPUT_CRLF_EN by extending the expected character list.
module tb_uart_sr_output;

    localparam int unsigned DW = 8;
    localparam int unsigned CC = 4;
`ifdef UART_SR_OUTPUT_CRLF_EN
    localparam int NEXP = CC + 2;
`else
    localparam int NEXP = CC;
`endif

    logic              clk;
    logic              reset_n;
    logic              ena;
    logic              load;
    logic [DW*CC-1:0]  sr_data;
    logic [DW-1:0]     tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    logic [7:0] exp_seq [NEXP];
    int checks;
    int errors;

    uart_sr_output #(
        .DATA_WIDTH      (DW),
        .CHARACTER_COUNT (CC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ena      (ena),
        .load     (load),
        .sr_data  (sr_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse load for one cycle; returns on the first falling edge after it.
    task automatic do_load(input logic [DW*CC-1:0] d);
        @(negedge clk);
        sr_data = d;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        sr_data = 32'h5A5A_5A5A;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        ena      = 1'b1;
        load     = 1'b0;
        sr_data  = '0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got v=%b b=%b d=%b data=%h want 0 0 0 00",
                         c, tx_valid, busy, done, tx_data);
            end
        end
    endtask

    task automatic test_basic();
        tx_ready = 1'b1;
        do_load(32'h44_43_42_41);
        for (int c = 1; c <= NEXP + 2; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (c <= NEXP) begin
                if (tx_valid !== 1'b1 || tx_data !== exp_seq[c-1] || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_seq cyc=%0d got v=%b data=%h b=%b d=%b want 1 %h 1 0",
                             c, tx_valid, tx_data, busy, done, exp_seq[c-1]);
                end
            end else if (c == NEXP + 1) begin
                if (tx_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_finish got v=%b b=%b d=%b want 0 1 1", tx_valid, busy, done);
                end
            end else begin
                if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_idle got v=%b b=%b d=%b want 0 0 0", tx_valid, busy, done);
                end
            end
        end
    endtask

    task automatic test_throttle();
        int   k;
        int   ndone;
        logic pend;
        logic [7:0] pdata;
        logic seen_done;
        k = 0; ndone = 0; pend = 1'b0; pdata = '0; seen_done = 1'b0;
        tx_ready = 1'b0;
        do_load(32'h44_43_42_41);
        for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
            tx_ready = ((cyc % 3) == 2);
            if (pend) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== pdata) begin
                    errors++;
                    $display("FAIL throttle_hold got v=%b data=%h want 1 %h", tx_valid, tx_data, pdata);
                end
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                checks++;
                if (k != NEXP) begin
                    errors++;
                    $display("FAIL throttle_count got %0d want %0d", k, NEXP);
                end
            end
            if (tx_valid === 1'b1 && tx_ready) begin
                checks++;
                if (k >= NEXP || tx_data !== exp_seq[k]) begin
                    errors++;
                    $display("FAIL throttle_data idx=%0d got %h want %h", k, tx_data,
                             (k < NEXP) ? exp_seq[k] : 8'hxx);
                end
                k++;
            end
            pend  = (tx_valid === 1'b1) && !tx_ready;
            pdata = tx_data;
            @(negedge clk);
        end
        checks++;
        if (!seen_done || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL throttle_end got seen_done=%b d=%b b=%b want 1 0 0", seen_done, done, busy);
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_load_ignored();
        int   k;
        logic seen_done;
        k = 0; seen_done = 1'b0;
        tx_ready = 1'b1;
        do_load(32'h44_43_42_41);
        for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
            load = 1'b0;
            if (cyc == 1) begin
                load = 1'b1; sr_data = 32'hFFFF_FFFF;
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                load = 1'b1; sr_data = 32'hFFFF_FFFF;
            end
            if (tx_valid === 1'b1) begin
                checks++;
                if (k >= NEXP || tx_data !== exp_seq[k]) begin
                    errors++;
                    $display("FAIL ignore_data idx=%0d got %h want %h", k, tx_data,
                             (k < NEXP) ? exp_seq[k] : 8'hxx);
                end
                k++;
            end
            @(negedge clk);
        end
        load = 1'b0;
        checks++;
        if (!seen_done || k != NEXP || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_finish_load got done=%b n=%0d b=%b v=%b want 1 %0d 0 0",
                     seen_done, k, busy, tx_valid, NEXP);
        end
        do_load(32'h11_22_33_44);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h11 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reload got v=%b data=%h b=%b want 1 11 1", tx_valid, tx_data, busy);
        end
        repeat (NEXP + 3) @(negedge clk);
    endtask

    task automatic test_ena_hold();
        int   k;
        logic pend;
        logic [7:0] pdata;
        logic seen_done;
        k = 0; pend = 1'b0; pdata = '0; seen_done = 1'b0;
        tx_ready = 1'b1;
        ena = 1'b0;
        do_load(32'h44_43_42_41);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ena_load_ignored got b=%b v=%b want 0 0", busy, tx_valid);
        end
        ena = 1'b1;
        do_load(32'h44_43_42_41);
        for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
            ena = !(cyc >= 2 && cyc < 7);
            if (pend) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== pdata) begin
                    errors++;
                    $display("FAIL ena_hold got v=%b data=%h want 1 %h", tx_valid, tx_data, pdata);
                end
            end
            if (done === 1'b1) seen_done = 1'b1;
            if (tx_valid === 1'b1 && ena) begin
                checks++;
                if (k >= NEXP || tx_data !== exp_seq[k]) begin
                    errors++;
                    $display("FAIL ena_data idx=%0d got %h want %h", k, tx_data,
                             (k < NEXP) ? exp_seq[k] : 8'hxx);
                end
                k++;
            end
            pend  = (tx_valid === 1'b1) && !ena;
            pdata = tx_data;
            @(negedge clk);
        end
        ena = 1'b1;
        checks++;
        if (!seen_done || k != NEXP) begin
            errors++;
            $display("FAIL ena_resume got done=%b n=%0d want 1 %0d", seen_done, k, NEXP);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b1;
        do_load(32'h44_43_42_41);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async got v=%b b=%b d=%b data=%h want 0 0 0 00",
                     tx_valid, busy, done, tx_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_nodone cyc=%0d got d=%b b=%b v=%b want 0 0 0",
                         c, done, busy, tx_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_seq[0] = 8'h44;
        exp_seq[1] = 8'h43;
        exp_seq[2] = 8'h42;
        exp_seq[3] = 8'h41;
`ifdef UART_SR_OUTPUT_CRLF_EN
        exp_seq[4] = 8'h0D;
        exp_seq[5] = 8'h0A;
`endif
        test_reset();
        test_basic();
        test_throttle();
        test_load_ignored();
        test_ena_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_sr_output.md
Name: uart_sr_output

Overview:
Parallel-to-serial character unloader; the transmit-side counterpart of the UART receive shift register.
- Captures a packed DATA_WIDTH×CHARACTER_COUNT vector on a load strobe.
- Feeds characters one at a time to the UART transmitter over a valid/ready handshake.
- Sends oldest-first: highest slot first, slot 0 last. This matches the receive-side packing, so a received block echoes back in arrival order.

Parameters:
- DATA_WIDTH, 8, bits per character.
- CHARACTER_COUNT, 10, characters per block; must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; when low, all state holds.
- load  input  1  single-cycle request to capture sr_data and start a block.
- sr_data  input  DATA_WIDTH*CHARACTER_COUNT  packed block; slot i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- tx_data  output  DATA_WIDTH  character offered to the transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- busy  output  1  block in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse after the final character is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE; internal buffer, index, tx_data cleared to 0; tx_valid=0, busy=0, done=0.
- Transfer: occurs in any cycle where tx_valid && tx_ready && ena. tx_data and tx_valid must not change while tx_valid=1 and no transfer has occurred.
- ena=0: no state, buffer, index, or output changes. A tx_ready seen while ena=0 is not a transfer. load is ignored while ena=0.
- States: IDLE, SEND, FINISH.
- IDLE:
  - load && ena → copy sr_data into the buffer, index=CHARACTER_COUNT-1, enter SEND.
  - Next cycle: tx_valid=1, tx_data=buffer slot CHARACTER_COUNT-1.
  - Latency from load to first tx_valid: 1 cycle.
- SEND, on transfer:
  - index>0 → index−1; tx_data=new slot next cycle; tx_valid stays 1. Back-to-back transfers at one per cycle are supported.
  - index==0 → tx_valid=0, enter FINISH. (CRLF variant: see Optional Feature.)
- FINISH: done=1 for exactly one cycle, then IDLE. busy remains 1 during FINISH.
- busy = (state≠IDLE), registered.
- load while busy (including the FINISH cycle): ignored, no queuing. The buffer is never overwritten mid-block.
- sr_data may change freely after the load cycle.
- Index width: $clog2(CHARACTER_COUNT+2), minimum 1.
- CHARACTER_COUNT=1: a single transfer, then FINISH.
- Reset mid-block: aborts immediately; tx_valid drops asynchronously; no done pulse.

Optional Feature:
- Macro: UART_SR_OUTPUT_CRLF_EN.
- Defined:
  - After slot 0 is accepted, the block sends 8'h0D then 8'h0A, each under the same handshake rules, before FINISH.
  - Adds states SEND_CR and SEND_LF; a block is CHARACTER_COUNT+2 transfers.
  - With DATA_WIDTH>8, the terminator is zero-extended.
- Undefined: exactly CHARACTER_COUNT transfers; no extra states synthesized.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef (IDLE, SEND, SEND_CR, SEND_LF, FINISH; CR/LF encodings always present, unused without the macro);
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- Single flat module; no sub-module is needed. Buffer and index mux are local.

Test Plan (DATA_WIDTH=8, CHARACTER_COUNT=4 unless noted):
- Reset then idle, tx_ready=1 → tx_valid=0, busy=0, done=0, tx_data=0 for 20 cycles.
- load with sr_data=32'h44_43_42_41, tx_ready=1 always → tx_data sequence 0x44, 0x43, 0x42, 0x41 on 4 consecutive cycles starting 1 cycle after load. done pulses once, the cycle after the 0x41 transfer. busy is high for 5 cycles.
- Same load, tx_ready toggling 1-in-3 → every character held stable until accepted; sequence unchanged; no duplicated or dropped characters.
- Second load asserted mid-block with sr_data=32'hFFFFFFFF → ignored; output remains 0x44..0x41. A new load after done is accepted.
- ena=0 for 5 cycles in mid-block with tx_ready=1 → index frozen, no transfers. Sending resumes when ena returns high.
- reset_n pulsed low after the 2nd transfer → tx_valid=0 and busy=0 immediately, no done pulse. With UART_SR_OUTPUT_CRLF_EN defined, a normal block ends with 0x0D, 0x0A before done.
